// File: rtl/regbank_sequencer.sv
// Single-issue sequencer: accepts an instruction, drives register-bank read selects,
// runs the ALU with a bounded wait, then retires with a one-hot register write.
module regbank_sequencer #(
  parameter int unsigned ALU_TIMEOUT = 15,
  parameter logic [3:0]  NOP_OPCODE  = 4'hF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr_in,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [3:0]  source_1_sel,
  output logic [3:0]  source_2_sel,
  output logic [3:0]  alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [31:0] alu_result,
  output logic [15:0] reg_write_en,
  output logic [31:0] reg_write_data,
  output logic        busy,
  output logic [15:0] instr_count,
  output logic        timeout_err,
  input  logic        err_clear
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StWrite} state_e;

  localparam logic [7:0] WaitLast = 8'(ALU_TIMEOUT - 1);

  state_e     state_q;
  logic [3:0] dest_q;
  logic [7:0] wait_cnt_q;

  // Low half of the instruction word carries nothing for this block.
  logic unused_instr_low;
  assign unused_instr_low = ^instr_in[15:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      dest_q         <= 4'h0;
      wait_cnt_q     <= 8'h00;
      source_1_sel   <= 4'h0;
      source_2_sel   <= 4'h0;
      alu_op         <= 4'h0;
      reg_write_data <= 32'h0;
      instr_count    <= 16'h0;
      timeout_err    <= 1'b0;
    end else begin
      // An abort later in this block overrides the clear.
      if (err_clear) begin
        timeout_err <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (instr_valid) begin
            alu_op       <= instr_in[31:28];
            dest_q       <= instr_in[27:24];
            source_1_sel <= instr_in[23:20];
            source_2_sel <= instr_in[19:16];
            if (instr_in[31:28] == NOP_OPCODE) begin
              instr_count <= instr_count + 16'h1;
            end else begin
              state_q <= StIssue;
            end
          end
        end
        StIssue: begin
          wait_cnt_q <= 8'h00;
          state_q    <= StWait;
        end
        StWait: begin
          if (alu_done) begin
            reg_write_data <= alu_result;
            state_q        <= StWrite;
          end else if (wait_cnt_q == WaitLast) begin
            timeout_err <= 1'b1;
            state_q     <= StIdle;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'h1;
          end
        end
        StWrite: begin
          instr_count <= instr_count + 16'h1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Remaining outputs decode from registered state only.
  assign instr_ready  = (state_q == StIdle);
  assign busy         = (state_q != StIdle);
  assign alu_start    = (state_q == StIssue);
  assign reg_write_en = (state_q == StWrite) ? (16'h0001 << dest_q) : 16'h0000;

  a_write_onehot0 : assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(reg_write_en));

endmodule

// File: tb/tb_regbank_sequencer.sv
// Randomized self-checking bench for regbank_sequencer against an instruction-level model.
module tb_regbank_sequencer;

  localparam int unsigned TO  = 15;
  localparam logic [3:0]  NOP = 4'hF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr_in;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  source_1_sel;
  logic [3:0]  source_2_sel;
  logic [3:0]  alu_op;
  logic        alu_start;
  logic        alu_done;
  logic [31:0] alu_result;
  logic [15:0] reg_write_en;
  logic [31:0] reg_write_data;
  logic        busy;
  logic [15:0] instr_count;
  logic        timeout_err;
  logic        err_clear;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_count;
  logic        exp_err;

  regbank_sequencer #(.ALU_TIMEOUT(TO), .NOP_OPCODE(NOP)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .instr_in       (instr_in),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .source_1_sel   (source_1_sel),
    .source_2_sel   (source_2_sel),
    .alu_op         (alu_op),
    .alu_start      (alu_start),
    .alu_done       (alu_done),
    .alu_result     (alu_result),
    .reg_write_en   (reg_write_en),
    .reg_write_data (reg_write_data),
    .busy           (busy),
    .instr_count    (instr_count),
    .timeout_err    (timeout_err),
    .err_clear      (err_clear)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    n_checks++;
    if ({instr_ready, busy, alu_start, reg_write_en, reg_write_data, source_1_sel, source_2_sel,
         alu_op, instr_count, timeout_err} !== {1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 4'h0,
         4'h0, 16'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL %s: rdy=%b busy=%b start=%b we=%h wd=%h s1=%h s2=%h op=%h cnt=%h err=%b, required reset values",
               tag, instr_ready, busy, alu_start, reg_write_en, reg_write_data, source_1_sel,
               source_2_sel, alu_op, instr_count, timeout_err);
    end
  endtask

  // Drives one instruction through the full handshake; lat is the WAIT cycle (1-based)
  // on which alu_done is raised, with lat > TO meaning the ALU never answers.
  task automatic run_instr(input logic [31:0] word, input int lat, input logic [31:0] res);
    logic [3:0]  op, d, s1, s2;
    logic [15:0] exp_we;
    int          w;
    bit          finished;
    op = word[31:28]; d = word[27:24]; s1 = word[23:20]; s2 = word[19:16];
    exp_we = 16'h0001 << d;
    n_checks++;
    if (instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_before_accept: got %b want 1", instr_ready);
    end
    instr_in = word;
    instr_valid = 1'b1;
    tick();
    // Garbage offered while busy must be ignored.
    instr_in = $urandom;
    instr_valid = 1'($urandom % 2);
    if (op == NOP) begin
      instr_valid = 1'b0;
      exp_count++;
      n_checks++;
      if (busy !== 1'b0 || alu_start !== 1'b0 || reg_write_en !== 16'h0 ||
          instr_count !== exp_count) begin
        n_fail++;
        $display("FAIL nop_retire: busy=%b start=%b we=%h cnt=%h want 0 0 0000 %h",
                 busy, alu_start, reg_write_en, instr_count, exp_count);
      end
      return;
    end
    n_checks++;
    if (alu_start !== 1'b1 || busy !== 1'b1 || instr_ready !== 1'b0 || source_1_sel !== s1 ||
        source_2_sel !== s2 || alu_op !== op || reg_write_en !== 16'h0) begin
      n_fail++;
      $display("FAIL issue: start=%b busy=%b rdy=%b s1=%h s2=%h op=%h we=%h want 1 1 0 %h %h %h 0000",
               alu_start, busy, instr_ready, source_1_sel, source_2_sel, alu_op, reg_write_en,
               s1, s2, op);
    end
    alu_done = 1'($urandom % 2);
    alu_result = $urandom;
    w = 0;
    finished = 0;
    while (!finished) begin
      tick();
      w++;
      alu_done = 1'b0;
      n_checks++;
      if (alu_start !== 1'b0 || busy !== 1'b1 || reg_write_en !== 16'h0 || instr_ready !== 1'b0 ||
          source_1_sel !== s1 || source_2_sel !== s2 || alu_op !== op) begin
        n_fail++;
        $display("FAIL wait_%0d: start=%b busy=%b we=%h rdy=%b s1=%h s2=%h op=%h want 0 1 0000 0 %h %h %h",
                 w, alu_start, busy, reg_write_en, instr_ready, source_1_sel, source_2_sel,
                 alu_op, s1, s2, op);
      end
      if (w == lat) begin
        alu_done = 1'b1;
        alu_result = res;
        tick();
        alu_done = 1'b0;
        alu_result = $urandom;
        n_checks++;
        if (reg_write_en !== exp_we || reg_write_data !== res || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL write: we=%h wd=%h busy=%b want %h %h 1", reg_write_en, reg_write_data,
                   busy, exp_we, res);
        end
        tick();
        instr_valid = 1'b0;
        exp_count++;
        n_checks++;
        if (instr_ready !== 1'b1 || reg_write_en !== 16'h0 || instr_count !== exp_count ||
            timeout_err !== exp_err) begin
          n_fail++;
          $display("FAIL retire: rdy=%b we=%h cnt=%h err=%b want 1 0000 %h %b", instr_ready,
                   reg_write_en, instr_count, timeout_err, exp_count, exp_err);
        end
        finished = 1;
      end else if (w == TO) begin
        // Clear landing on the abort cycle must lose.
        err_clear = 1'($urandom % 2);
        tick();
        err_clear = 1'b0;
        instr_valid = 1'b0;
        exp_err = 1'b1;
        n_checks++;
        if (instr_ready !== 1'b1 || timeout_err !== 1'b1 || reg_write_en !== 16'h0 ||
            instr_count !== exp_count) begin
          n_fail++;
          $display("FAIL abort: rdy=%b err=%b we=%h cnt=%h want 1 1 0000 %h", instr_ready,
                   timeout_err, reg_write_en, instr_count, exp_count);
        end
        finished = 1;
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #12;
    check_reset_values("reset_held");
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    exp_count = 16'h0;
    exp_err = 1'b0;
  endtask

  task automatic test_reset();
    instr_in = 32'h0; instr_valid = 1'b0; alu_done = 1'b0; alu_result = 32'h0; err_clear = 1'b0;
    do_reset();
    check_reset_values("reset_released");
  endtask

  task automatic test_directed_alu();
    run_instr(32'h3A45_0000, 1, 32'hDEADBEEF);
    n_checks++;
    if (instr_count !== 16'h1) begin
      n_fail++;
      $display("FAIL directed_count: got %h want 0001", instr_count);
    end
  endtask

  task automatic test_back_to_back_nops();
    logic [15:0] base;
    base = exp_count;
    instr_in = 32'hF000_0000;
    instr_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++;
      if (instr_ready !== 1'b1 || busy !== 1'b0 || alu_start !== 1'b0 || reg_write_en !== 16'h0 ||
          instr_count !== base + 16'(i)) begin
        n_fail++;
        $display("FAIL nop_b2b_%0d: rdy=%b busy=%b start=%b we=%h cnt=%h want 1 0 0 0000 %h", i,
                 instr_ready, busy, alu_start, reg_write_en, instr_count, base + 16'(i));
      end
    end
    instr_valid = 1'b0;
    exp_count = base + 16'd3;
  endtask

  task automatic test_timeout();
    run_instr(32'h1234_0000, TO + 5, 32'h0);
    // Error flag must not block acceptance.
    run_instr(32'hF000_0000, 0, 32'h0);
    n_checks++;
    if (timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %b want 1", timeout_err);
    end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    exp_err = 1'b0;
    n_checks++;
    if (timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got %b want 0", timeout_err);
    end
  endtask

  task automatic test_done_on_last_wait();
    run_instr(32'h5C12_0000, TO, 32'hCAFE_F00D);
    n_checks++;
    if (timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL last_wait_err: got %b want 0", timeout_err);
    end
  endtask

  task automatic test_reset_mid_wait();
    instr_in = 32'h2765_0000;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("reset_mid_wait");
    @(negedge clk);
    reset_n = 1'b1;
    exp_count = 16'h0;
    exp_err = 1'b0;
    for (int i = 0; i < 20; i++) begin
      alu_done = 1'($urandom % 2);
      tick();
      n_checks++;
      if (reg_write_en !== 16'h0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_idle_%0d: we=%h busy=%b want 0000 0", i, reg_write_en, busy);
      end
    end
    alu_done = 1'b0;
    run_instr(32'h4089_0000, 3, 32'h1357_9BDF);
  endtask

  task automatic test_random();
    logic [31:0] word;
    for (int i = 0; i < 60; i++) begin
      word = $urandom;
      if ($urandom % 4 == 0) word[31:28] = NOP;
      run_instr(word, 1 + int'($urandom % (TO + 4)), $urandom);
      if ($urandom % 5 == 0) begin
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        exp_err = 1'b0;
        n_checks++;
        if (timeout_err !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_clear_%0d: got %b want 0", i, timeout_err);
        end
      end
    end
  endtask

  task automatic test_count_wrap();
    do_reset();
    instr_in = 32'hF000_0000;
    instr_valid = 1'b1;
    for (int i = 0; i < 65535; i++) tick();
    instr_valid = 1'b0;
    exp_count = 16'hFFFF;
    n_checks++;
    if (instr_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL count_preload: got %h want ffff", instr_count);
    end
    run_instr(32'h6E01_0000, 2, 32'h0BAD_C0DE);
    n_checks++;
    if (instr_count !== 16'h0000) begin
      n_fail++;
      $display("FAIL count_wrap: got %h want 0000", instr_count);
    end
  endtask

  initial begin
    test_reset();
    test_directed_alu();
    test_back_to_back_nops();
    test_timeout();
    test_done_on_last_wait();
    test_reset_mid_wait();
    test_random();
    test_count_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regbank_sequencer.md
# regbank_sequencer

Single-issue instruction sequencer for the 16 x 32-bit register bank. Accepts one 32-bit instruction word at a time over a valid/ready handshake, and drives the source_1/source_2 read-mux selects. It also starts the ALU, waits for its result (with a timeout), then issues exactly one one-hot write enable into the register bank. The block sits between instruction fetch and the register bank / ALU datapath.

## Interface
Parameters:
- ALU_TIMEOUT, 15: number of WAIT cycles allowed before an ALU operation is aborted; legal range 1..255.
- NOP_OPCODE, 4'hF: opcode that retires without ALU use or register write.

Ports:
- clk  in  1  single system clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- instr_in  in  32  instruction word: opcode [31:28], dest [27:24], source_1 [23:20], source_2 [19:16], [15:0] unused.
- instr_valid  in  1  instr_in is valid this cycle.
- instr_ready  out  1  sequencer can accept an instruction this cycle.
- source_1_sel  out  4  read select for register bank mux 1.
- source_2_sel  out  4  read select for register bank mux 2.
- alu_op  out  4  latched opcode presented to the ALU.
- alu_start  out  1  one-cycle pulse that starts the ALU.
- alu_done  in  1  ALU result valid this cycle.
- alu_result  in  32  ALU result, sampled when alu_done=1 in WAIT.
- reg_write_en  out  16  one-hot register write enable; bit n writes register n.
- reg_write_data  out  32  data for the register selected by reg_write_en.
- busy  out  1  high in any state other than IDLE.
- instr_count  out  16  number of retired instructions; wraps.
- timeout_err  out  1  sticky flag: an ALU operation was aborted.
- err_clear  in  1  synchronous clear of timeout_err.

## Operation
- FSM states: IDLE, ISSUE, WAIT, WRITE. All outputs are registered or decoded from state only; no input-to-output combinational paths.
- IDLE: instr_ready=1.
  - On instr_valid & instr_ready, latch opcode/dest/source_1/source_2.
  - If the opcode equals NOP_OPCODE: stay in IDLE and increment instr_count.
  - Otherwise: go to ISSUE.
- ISSUE: alu_start=1 for this one cycle; clear the timeout counter; go to WAIT. alu_done is ignored in ISSUE.
- WAIT:
  - If alu_done=1: capture alu_result into reg_write_data and go to WRITE.
  - Otherwise, if the counter equals ALU_TIMEOUT-1: set timeout_err, go to IDLE, and perform no write and no count increment.
  - Otherwise: increment the counter.
  - If alu_done and the timeout land on the same cycle, alu_done wins.
- WRITE: reg_write_en = 16'b1 << dest for exactly one cycle; instr_count += 1; go to IDLE.
- reg_write_en is 16'h0000 in every state except WRITE. It never has more than one bit set.
- source_1_sel, source_2_sel and alu_op hold their latched values from acceptance until the next acceptance. This keeps the register bank read data stable through WAIT.
- Register 0 is an ordinary register; dest=0 writes it.
- instr_count wraps 16'hFFFF -> 16'h0000.
- timeout_err:
  - Set by an abort; cleared by err_clear=1.
  - If an abort and err_clear occur in the same cycle, set wins.
  - timeout_err does not block acceptance of new instructions.

## Timing
- Reset (reset_n=0, asynchronous): state=IDLE, instr_ready=1, busy=0, alu_start=0, reg_write_en=0, reg_write_data=0, source_1_sel=0, source_2_sel=0, alu_op=0, instr_count=0, timeout_err=0.
- Reset mid-operation aborts the instruction immediately. No write enable may appear after reset_n deasserts.
- Accept at edge 0:
  - ISSUE in cycle 1, with alu_start high.
  - Earliest alu_done is sampled in cycle 2 (WAIT).
  - WRITE in cycle 3.
  - instr_ready high again in cycle 4.
- Minimum of 4 cycles per ALU instruction; a NOP occupies 1 cycle (back-to-back NOPs are accepted every cycle).
- Timeout: with alu_done never asserted, WAIT lasts exactly ALU_TIMEOUT cycles. IDLE is entered on the following edge, and timeout_err is visible in that same cycle.
- instr_ready is low in ISSUE/WAIT/WRITE. instr_valid presented then is ignored and must be held by the sender.

## Test plan
- Reset then instr_in=32'h3A45_0000, valid one cycle, alu_done with alu_result=32'hDEADBEEF on the first WAIT cycle:
  - alu_start pulses in cycle 1 with source_1_sel=4, source_2_sel=5, alu_op=3.
  - reg_write_en=16'h0400 and reg_write_data=32'hDEADBEEF for one cycle in cycle 3.
  - instr_count=1.
- Three back-to-back NOP words 32'hF000_0000: accepted on three consecutive cycles, instr_count=3, reg_write_en stays 0, alu_start never pulses.
- ALU_TIMEOUT=15, alu_done held low:
  - WAIT lasts 15 cycles, then IDLE with timeout_err=1.
  - No write; instr_count is unchanged.
  - err_clear pulse returns timeout_err to 0.
- alu_done asserted on exactly the 15th WAIT cycle: the write occurs and timeout_err stays 0.
- reset_n pulsed low during WAIT: all outputs return to reset values immediately, no write follows, and the next instruction completes normally.
- Preload instr_count to 16'hFFFF via 65535 NOPs, then retire one more instruction: instr_count=16'h0000.
